// File: rtl/prog_tick_divider_if.sv
// Bundle for the programmable tick divider: run enables,
// divisor configuration bus and per-channel tick outputs.
interface prog_tick_divider_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 26
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq_out;
    logic [NUM_CH-1:0] cfg_pending;

    modport master (
        output en, cfg_wr, cfg_ch, cfg_div,
        input  tick, sq_out, cfg_pending
    );

    modport slave (
        input  en, cfg_wr, cfg_ch, cfg_div,
        output tick, sq_out, cfg_pending
    );
endinterface

// File: rtl/prog_tick_divider.sv
// Multi-channel programmable tick divider with glitch-free
// divisor updates applied at each channel's terminal count.
module prog_tick_divider #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    prog_tick_divider_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] div_shd;
        logic             tick_r;
        logic             sq_r;
        logic             pend_r;
        logic [CNT_W-1:0] d_eff;
        logic             run;
        logic             term;
        logic             hit;

        // A programmed divisor of zero runs as divide-by-one.
        assign d_eff = (div_act == '0) ? ONE : div_act;
        assign run   = bus.en[i];
        assign term  = run && (cnt >= d_eff - ONE);
        assign hit   = bus.cfg_wr && (bus.cfg_ch == CH_W'(i));

        assign bus.tick[i]        = tick_r;
        assign bus.sq_out[i]      = sq_r;
        assign bus.cfg_pending[i] = pend_r;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt     <= '0;
                div_act <= DEF;
                div_shd <= DEF;
                tick_r  <= 1'b0;
                sq_r    <= 1'b0;
                pend_r  <= 1'b0;
            end else begin
                if (!run) begin
                    cnt    <= '0;
                    tick_r <= 1'b0;
                    sq_r   <= 1'b0;
                end else if (term) begin
                    cnt    <= '0;
                    tick_r <= 1'b1;
                    sq_r   <= ~sq_r;
                end else begin
                    cnt    <= cnt + ONE;
                    tick_r <= 1'b0;
                end

                // Idle or wrapping channels take a write at once;
                // a running channel holds it until its next wrap.
                if (hit) begin
                    div_shd <= bus.cfg_div;
                    if (!run || term) begin
                        div_act <= bus.cfg_div;
                        pend_r  <= 1'b0;
                    end else begin
                        pend_r  <= 1'b1;
                    end
                end else if (term && pend_r) begin
                    div_act <= div_shd;
                    pend_r  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_prog_tick_divider.sv
// Scoreboard bench for prog_tick_divider: expected tick events
// are queued by the stimulus and checked by a negedge monitor.
module tb_prog_tick_divider;
    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int DDIV = 10;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] tk;
        logic [NCH-1:0] sq;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    ev_t  q[$];

    prog_tick_divider_if #(.NUM_CH(NCH), .CNT_W(CW)) bus();

    prog_tick_divider #(
        .NUM_CH(NCH),
        .CNT_W(CW),
        .DEFAULT_DIV(DDIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (reset && bus.tick != '0) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_tick cyc=%0d tick=%b sq=%b",
                         cyc, bus.tick, bus.sq_out);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || bus.tick != e.tk || bus.sq_out != e.sq) begin
                    fails++;
                    $display("FAIL tick_event got cyc=%0d tick=%b sq=%b want cyc=%0d tick=%b sq=%b",
                             cyc, bus.tick, bus.sq_out, e.cyc, e.tk, e.sq);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_tick(input int c, input logic [NCH-1:0] tk,
                               input logic [NCH-1:0] sq);
        ev_t e;
        e.cyc = c;
        e.tk  = tk;
        e.sq  = sq;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input int ch, input int dv);
        bus.cfg_wr  = 1'b1;
        bus.cfg_ch  = 2'(ch);
        bus.cfg_div = CW'(dv);
        step(1);
        bus.cfg_wr  = 1'b0;
    endtask

    initial begin
        int b;
        bus.en      = '0;
        bus.cfg_wr  = 1'b0;
        bus.cfg_ch  = '0;
        bus.cfg_div = '0;
        #2 reset = 1'b0;
        #1;
        chk("reset_tick", bus.tick, 0);
        chk("reset_sq", bus.sq_out, 0);
        chk("reset_pend", bus.cfg_pending, 0);
        #9 reset = 1'b1;
        step(1);

        // ch0 at default divisor, then a 5-cycle disable
        b = cyc;
        bus.en = 3'b001;
        expect_tick(b + 10, 3'b001, 3'b001);
        expect_tick(b + 20, 3'b001, 3'b000);
        expect_tick(b + 30, 3'b001, 3'b001);
        step(9);
        chk("a_no_early_tick", bus.tick, 0);
        step(1);
        chk("a_first_sq", bus.sq_out, 3'b001);
        step(23);
        bus.en = 3'b000;
        step(1);
        chk("a_dis_tick", bus.tick, 0);
        chk("a_dis_sq", bus.sq_out, 0);
        step(4);
        bus.en = 3'b001;
        expect_tick(b + 48, 3'b001, 3'b001);
        step(12);
        bus.en = 3'b000;
        step(2);

        // ch1 D=8, rewrite to 3 while cnt=2
        wr(1, 8);
        chk("b_idle_wr_pend", bus.cfg_pending, 0);
        b = cyc;
        bus.en = 3'b010;
        expect_tick(b + 8,  3'b010, 3'b010);
        expect_tick(b + 16, 3'b010, 3'b000);
        expect_tick(b + 19, 3'b010, 3'b010);
        expect_tick(b + 22, 3'b010, 3'b000);
        expect_tick(b + 25, 3'b010, 3'b010);
        step(10);
        wr(1, 3);
        chk("b_pend_set", bus.cfg_pending, 3'b010);
        step(4);
        chk("b_pend_hold", bus.cfg_pending, 3'b010);
        step(1);
        chk("b_pend_clr", bus.cfg_pending, 0);
        step(10);
        bus.en = 3'b000;
        step(2);

        // ch2 D=4, then divisor 0 and 1 (tick every cycle)
        wr(2, 4);
        b = cyc;
        bus.en = 3'b100;
        expect_tick(b + 4, 3'b100, 3'b100);
        expect_tick(b + 8, 3'b100, 3'b000);
        for (int k = 9; k <= 14; k++)
            expect_tick(b + k, 3'b100, (k % 2 == 1) ? 3'b100 : 3'b000);
        step(5);
        wr(2, 0);
        chk("c_zero_pend", bus.cfg_pending, 3'b100);
        step(2);
        chk("c_zero_applied", bus.cfg_pending, 0);
        step(3);
        wr(2, 1);
        chk("c_one_no_pend", bus.cfg_pending, 0);
        step(2);
        bus.en = 3'b000;
        step(2);

        // ch0 write on terminal count, then out-of-range channel
        b = cyc;
        bus.en = 3'b001;
        expect_tick(b + 10, 3'b001, 3'b001);
        expect_tick(b + 15, 3'b001, 3'b000);
        expect_tick(b + 20, 3'b001, 3'b001);
        step(9);
        wr(0, 5);
        chk("d_term_wr_pend", bus.cfg_pending, 0);
        wr(NCH, 2);
        chk("d_bad_ch_pend", bus.cfg_pending, 0);
        step(9);
        bus.en = 3'b000;
        step(2);

        // async reset with a pending write on ch1
        b = cyc;
        bus.en = 3'b010;
        expect_tick(b + 3, 3'b010, 3'b010);
        step(4);
        wr(1, 7);
        chk("e_pend_before_rst", bus.cfg_pending, 3'b010);
        #2 reset = 1'b0;
        #1;
        chk("e_rst_tick", bus.tick, 0);
        chk("e_rst_sq", bus.sq_out, 0);
        chk("e_rst_pend", bus.cfg_pending, 0);
        #2 reset = 1'b1;
        expect_tick(b + 15, 3'b010, 3'b010);
        expect_tick(b + 25, 3'b010, 3'b000);
        step(1);
        chk("e_post_rst_pend", bus.cfg_pending, 0);
        step(20);
        bus.en = 3'b000;
        step(5);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_ticks got=%0d left want=0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
